// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, coordinate width and FSM state type
package vga_pkg;

    // Default 640x480@60 timing (25.175 MHz pixel clock)
    localparam int VGA_H_VIS       = 640;
    localparam int VGA_H_FP        = 16;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BP        = 48;
    localparam int VGA_V_VIS       = 480;
    localparam int VGA_V_FP        = 10;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BP        = 33;
    localparam bit VGA_SYNC_POL    = 1'b0;
    localparam int VGA_LOCK_CYCLES = 16;

    // Raster counters and pixel coordinates share this width
    localparam int VGA_COORD_W     = 10;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_e;

endpackage

// File: rtl/lock_qualifier.sv
// rtl/lock_qualifier.sv - PLL lock synchronizer and stability counter
//   clk          in  pixel clock
//   rst_n        in  asynchronous active-low reset
//   i_locked     in  raw PLL locked flag (asynchronous to clk)
//   o_lock_ok    out lock has been seen for LOCK_CYCLES consecutive synchronized cycles
//   o_lock_lost  out synchronized lock is currently low
module lock_qualifier #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_locked,
    output logic o_lock_ok,
    output logic o_lock_lost
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES - 1);

    logic             r_meta;
    logic             r_lk_s;
    logic [CNT_W-1:0] r_lock_cnt;

    // The counter saturates so a long stable lock keeps o_lock_ok high; any
    // synchronized low clears it and qualification starts over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta     <= 1'b0;
            r_lk_s     <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_meta <= i_locked;
            r_lk_s <= r_meta;
            if (!r_lk_s) begin
                r_lock_cnt <= '0;
            end else if (r_lock_cnt != CNT_MAX) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end

    assign o_lock_ok   = r_lk_s && (r_lock_cnt == CNT_MAX);
    assign o_lock_lost = !r_lk_s;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator gated by qualified PLL lock
//   clk            in  pixel clock
//   rst_n          in  asynchronous active-low reset
//   pll_locked_i   in  PLL locked flag (asynchronous)
//   hsync_o        out horizontal sync, active level SYNC_POL
//   vsync_o        out vertical sync, active level SYNC_POL
//   de_o           out visible-area data enable
//   pix_x_o        out visible column, 0 outside visible area
//   pix_y_o        out visible row, 0 outside visible area
//   line_start_o   out pulse on first pixel period of each line
//   frame_start_o  out pulse on first pixel period of each frame
//   running_o      out FSM is in RUN (one cycle ahead of the decoded outputs)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS       = VGA_H_VIS,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VIS       = VGA_V_VIS,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit SYNC_POL    = VGA_SYNC_POL,
    parameter int LOCK_CYCLES = VGA_LOCK_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked_i,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   de_o,
    output logic [VGA_COORD_W-1:0] pix_x_o,
    output logic [VGA_COORD_W-1:0] pix_y_o,
    output logic                   line_start_o,
    output logic                   frame_start_o,
    output logic                   running_o
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Compare in one extra bit so a total of exactly 1024 is representable
    localparam int EW = VGA_COORD_W + 1;
    localparam logic [EW-1:0] C_H_VIS    = EW'(H_VIS);
    localparam logic [EW-1:0] C_V_VIS    = EW'(V_VIS);
    localparam logic [EW-1:0] C_H_LAST   = EW'(H_TOT - 1);
    localparam logic [EW-1:0] C_V_LAST   = EW'(V_TOT - 1);
    localparam logic [EW-1:0] C_HS_START = EW'(H_VIS + H_FP);
    localparam logic [EW-1:0] C_HS_END   = EW'(H_VIS + H_FP + H_SYNC);
    localparam logic [EW-1:0] C_VS_START = EW'(V_VIS + V_FP);
    localparam logic [EW-1:0] C_VS_END   = EW'(V_VIS + V_FP + V_SYNC);

    vga_state_e              r_state;
    vga_state_e              w_next_state;
    logic [VGA_COORD_W-1:0]  r_h_cnt;
    logic [VGA_COORD_W-1:0]  r_v_cnt;
    logic                    w_lock_ok;
    logic                    w_lock_lost;
    logic                    w_advance;
    logic [EW-1:0]           w_h;
    logic [EW-1:0]           w_v;
    logic                    w_de;
    logic                    w_hs_act;
    logic                    w_vs_act;

    lock_qualifier #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_qualifier (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_locked    (pll_locked_i),
        .o_lock_ok   (w_lock_ok),
        .o_lock_lost (w_lock_lost)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_LOCK: if (w_lock_ok)   w_next_state = RUN;
            RUN:       if (w_lock_lost) w_next_state = WAIT_LOCK;
            default:                    w_next_state = WAIT_LOCK;
        endcase
    end

    // Counters only move while staying in RUN; entering RUN therefore starts
    // at h=v=0 and a lock loss abandons the current position.
    assign w_advance = (r_state == RUN) && (w_next_state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_advance) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h == C_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (w_v == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_h      = {1'b0, r_h_cnt};
    assign w_v      = {1'b0, r_v_cnt};
    assign w_de     = (w_h < C_H_VIS) && (w_v < C_V_VIS);
    assign w_hs_act = (w_h >= C_HS_START) && (w_h < C_HS_END);
    assign w_vs_act = (w_v >= C_VS_START) && (w_v < C_VS_END);

    // Single output register stage; decoding keys off the current state so the
    // cycle after leaving RUN returns every output to its idle value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            de_o          <= 1'b0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (r_state == RUN) begin
            hsync_o       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            de_o          <= w_de;
            pix_x_o       <= w_de ? r_h_cnt : '0;
            pix_y_o       <= w_de ? r_v_cnt : '0;
            line_start_o  <= (r_h_cnt == '0);
            frame_start_o <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end else begin
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            de_o          <= 1'b0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end
    end

    assign running_o = (r_state == RUN);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 raster timing in the 25.175 MHz pixel clock domain.
- Provides hsync, vsync, data-enable, pixel coordinates and frame/line strobes to the Tetris renderer.
- Sits directly downstream of the pixel-clock PLL. Consumes its pixel clock output and its locked flag.
- Holds the raster idle until lock has been stable for a qualification interval. Returns to idle on loss of lock.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- LOCK_CYCLES, 16, consecutive locked cycles required before the raster starts

Ports:
- clk  in  1  pixel clock (PLL outclk_0, 25.175 MHz)
- rst_n  in  1  asynchronous active-low reset
- pll_locked_i  in  1  PLL locked flag (asynchronous to clk)
- hsync_o  out  1  horizontal sync, polarity per SYNC_POL
- vsync_o  out  1  vertical sync, polarity per SYNC_POL
- de_o  out  1  high during the visible area
- pix_x_o  out  10  visible column 0..H_VIS-1; 0 when de_o=0
- pix_y_o  out  10  visible row 0..V_VIS-1; 0 when de_o=0
- line_start_o  out  1  one-cycle pulse coincident with the first pixel period of every line
- frame_start_o  out  1  one-cycle pulse coincident with h=0, v=0
- running_o  out  1  high while the FSM is in RUN

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, active-low. Deassertion is used directly; the PLL holds clk quiet until lock.
- Reset values: hsync_o=vsync_o=~SYNC_POL (inactive), de_o=0, pix_x_o=pix_y_o=0, line_start_o=frame_start_o=0, running_o=0. Internally h_cnt=v_cnt=0, lock_cnt=0, state=WAIT_LOCK.
- Lock input: pll_locked_i goes through a 2-flop synchronizer to produce lk_s.
- Derived totals: H_TOT=H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT=V_VIS+V_FP+V_SYNC+V_BP (525). Counters are 10 bits; the parameters must satisfy H_TOT≤1024 and V_TOT≤1024.
- FSM:
  - WAIT_LOCK: lock_cnt increments while lk_s=1 and clears to 0 when lk_s=0. When lock_cnt==LOCK_CYCLES-1 and lk_s=1, go to RUN with h_cnt=v_cnt=0.
  - RUN: if lk_s=0, go to WAIT_LOCK immediately, clear lock_cnt/h_cnt/v_cnt, and force outputs to reset values on the next edge. The line/frame in progress is abandoned and never completed.
- Counters in RUN:
  - h_cnt wraps H_TOT-1 → 0.
  - On that wrap, v_cnt increments and wraps V_TOT-1 → 0 (simultaneous wrap at h=H_TOT-1, v=V_TOT-1).
- Decode, registered for exactly one cycle of latency from the counters:
  - de = (h_cnt<H_VIS)&&(v_cnt<V_VIS)
  - hsync active when H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC (656..751)
  - vsync active when V_VIS+V_FP ≤ v_cnt < V_VIS+V_FP+V_SYNC (490..491), for entire lines
  - line_start = (h_cnt==0)
  - frame_start = (h_cnt==0 && v_cnt==0)
  - pix_x/pix_y = h_cnt/v_cnt when de, else 0
  - All outputs share this single register stage and stay mutually aligned.
- Startup timing: the first RUN cycle has h=0, v=0. frame_start_o, line_start_o and de_o (with pix 0,0) assert on the following edge.
- running_o mirrors the state register, so it leads the other outputs by one cycle.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 timing constants
  - coordinate width constant (10)
  - FSM state enum {WAIT_LOCK, RUN}
- Natural sub-module: lock_qualifier (synchronizer plus lock_cnt). It outputs a qualified-lock level and a lost-lock condition; the raster counters and decode stay in the top.

Test Plan:
- Reset with locked=1 throughout → all outputs at reset values. running_o rises 2 (sync) + 16 cycles after rst_n release. First frame_start_o arrives one cycle later with de_o=1 and pix 0,0.
- Steady RUN over 2 full frames → frame_start_o period is 420000 cycles, line_start_o period is 800, hsync_o low for 96 cycles starting at h=656, vsync_o low for 1600 cycles starting at v=490, de_o high for 640×480 cycles per frame.
- Coordinates → pix_x_o sweeps 0..639 while de_o=1. On line 479, pixel 639 is followed by de_o=0 with pix 0,0, and the next de_o=1 occurs at frame_start_o.
- Locked glitch during qualification (locked=1 for 10 cycles, 0 for 1, then 1) → lock_cnt restarts, and running_o rises 16 cycles after the final rise plus synchronizer delay.
- Locked drops mid-line at h=300, v=100 → after synchronizer delay, running_o=0, and one edge later de_o=0 with syncs inactive. After relock, the raster restarts with frame_start_o and pix 0,0.
- Async rst_n asserted mid-frame between clock edges → outputs take reset values immediately, without waiting for a clock edge.
